// File: rtl/mesh_out_deskew.sv
// Re-aligns the skewed bottom-row outputs of the PE mesh into one row, then applies a rounding shift and int8 saturation.
// Optional saturation counter port io_sat_count is enabled by defining MESH_OUT_SAT_COUNT_EN.
module mesh_out_deskew #(
    parameter int COLS  = 4,
    parameter int DBITS = 32,
    parameter int OBITS = 8,
    parameter int SHW   = 6
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [COLS*DBITS-1:0]  io_in_c,
    input  logic [COLS-1:0]        io_in_valid,
    input  logic [SHW-1:0]         io_in_shift,
    input  logic                   io_in_propagate,
    output logic [COLS*OBITS-1:0]  io_out_c,
    output logic                   io_out_valid,
    output logic                   io_out_propagate,
    output logic                   io_err_misalign
`ifdef MESH_OUT_SAT_COUNT_EN
    ,
    output logic [15:0]            io_sat_count
`endif
);

    localparam logic signed [DBITS:0] MAXV = (DBITS+1)'((1 << (OBITS-1)) - 1);
    localparam logic signed [DBITS:0] MINV = ~MAXV;

    logic [DBITS-1:0] alignC [COLS];
    logic [COLS-1:0]  alignV;
    logic [SHW-1:0]   alignShift;
    logic             alignProp;

    // Lane j waits COLS-1-j cycles so every lane of a row meets lane COLS-1.
    for (genvar j = 0; j < COLS; j++) begin : g_lane
        localparam int DEPTH = COLS - 1 - j;
        if (DEPTH == 0) begin : g_direct
            assign alignC[j] = io_in_c[j*DBITS +: DBITS];
            assign alignV[j] = io_in_valid[j];
        end else begin : g_delay
            logic [DBITS-1:0] laneC_q [DEPTH];
            logic [DEPTH-1:0] laneV_q;
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    for (int k = 0; k < DEPTH; k++) laneC_q[k] <= '0;
                    laneV_q <= '0;
                end else begin
                    laneC_q[0] <= io_in_c[j*DBITS +: DBITS];
                    laneV_q[0] <= io_in_valid[j];
                    for (int k = 1; k < DEPTH; k++) begin
                        laneC_q[k] <= laneC_q[k-1];
                        laneV_q[k] <= laneV_q[k-1];
                    end
                end
            end
            assign alignC[j] = laneC_q[DEPTH-1];
            assign alignV[j] = laneV_q[DEPTH-1];
        end
    end

    if (COLS == 1) begin : g_ctrl_direct
        assign alignShift = io_in_shift;
        assign alignProp  = io_in_propagate;
    end else begin : g_ctrl_delay
        logic [SHW:0] ctrl_q [COLS-1];
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                for (int k = 0; k < COLS-1; k++) ctrl_q[k] <= '0;
            end else begin
                ctrl_q[0] <= {io_in_propagate, io_in_shift};
                for (int k = 1; k < COLS-1; k++) ctrl_q[k] <= ctrl_q[k-1];
            end
        end
        assign alignShift = ctrl_q[COLS-2][SHW-1:0];
        assign alignProp  = ctrl_q[COLS-2][SHW];
    end

    logic [COLS*OBITS-1:0] rowVal;
    logic [COLS-1:0]       laneSat;
    logic [SHW-1:0]        sAmt;

    // One extra bit of headroom keeps max-positive plus the rounding bias from wrapping.
    always_comb begin
        logic signed [DBITS:0] xExt;
        logic signed [DBITS:0] bias;
        logic signed [DBITS:0] rnd;
        rowVal  = '0;
        laneSat = '0;
        sAmt    = (int'(alignShift) > DBITS - 1) ? SHW'(DBITS - 1) : alignShift;
        for (int j = 0; j < COLS; j++) begin
            xExt = {alignC[j][DBITS-1], alignC[j]};
            bias = '0;
            if (sAmt != '0) bias[sAmt - 1'b1] = 1'b1;
            rnd = (xExt + bias) >>> sAmt;
            if (rnd > MAXV) begin
                rowVal[j*OBITS +: OBITS] = MAXV[OBITS-1:0];
                laneSat[j] = 1'b1;
            end else if (rnd < MINV) begin
                rowVal[j*OBITS +: OBITS] = MINV[OBITS-1:0];
                laneSat[j] = 1'b1;
            end else begin
                rowVal[j*OBITS +: OBITS] = rnd[OBITS-1:0];
            end
        end
    end

    logic                  accept;
    logic                  mixed;
    logic [COLS*OBITS-1:0] outC_q, outC_d;
    logic                  outValid_q, outValid_d;
    logic                  outProp_q, outProp_d;
    logic                  err_q, err_d;

    // A partially valid row is a skew fault upstream: drop it and latch the error.
    always_comb begin
        accept     = &alignV;
        mixed      = (|alignV) && !accept;
        outValid_d = accept;
        outC_d     = accept ? rowVal : outC_q;
        outProp_d  = accept ? alignProp : outProp_q;
        err_d      = err_q | mixed;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            outC_q     <= '0;
            outValid_q <= 1'b0;
            outProp_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            outC_q     <= outC_d;
            outValid_q <= outValid_d;
            outProp_q  <= outProp_d;
            err_q      <= err_d;
        end
    end

    assign io_out_c         = outC_q;
    assign io_out_valid     = outValid_q;
    assign io_out_propagate = outProp_q;
    assign io_err_misalign  = err_q;

`ifdef MESH_OUT_SAT_COUNT_EN
    logic [15:0] satCnt_q, satCnt_d;
    logic [16:0] satSum;

    always_comb begin
        satSum = {1'b0, satCnt_q};
        for (int j = 0; j < COLS; j++) satSum = satSum + 17'(laneSat[j]);
        satCnt_d = satCnt_q;
        if (accept) satCnt_d = satSum[16] ? 16'hFFFF : satSum[15:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) satCnt_q <= '0;
        else       satCnt_q <= satCnt_d;
    end

    assign io_sat_count = satCnt_q;
`else
    logic unusedSat;
    assign unusedSat = ^laneSat;
`endif

endmodule

// File: tb/tb_mesh_out_deskew.sv
// Directed self-checking bench for mesh_out_deskew (COLS=4, DBITS=32, OBITS=8, SHW=6).
module tb_mesh_out_deskew;

    localparam int COLS  = 4;
    localparam int DBITS = 32;
    localparam int OBITS = 8;
    localparam int SHW   = 6;

    logic                  clock;
    logic                  reset;
    logic [COLS*DBITS-1:0] io_in_c;
    logic [COLS-1:0]       io_in_valid;
    logic [SHW-1:0]        io_in_shift;
    logic                  io_in_propagate;
    logic [COLS*OBITS-1:0] io_out_c;
    logic                  io_out_valid;
    logic                  io_out_propagate;
    logic                  io_err_misalign;
`ifdef MESH_OUT_SAT_COUNT_EN
    logic [15:0]           io_sat_count;
`endif

    mesh_out_deskew #(.COLS(COLS), .DBITS(DBITS), .OBITS(OBITS), .SHW(SHW)) dut (
        .clock            (clock),
        .reset            (reset),
        .io_in_c          (io_in_c),
        .io_in_valid      (io_in_valid),
        .io_in_shift      (io_in_shift),
        .io_in_propagate  (io_in_propagate),
        .io_out_c         (io_out_c),
        .io_out_valid     (io_out_valid),
        .io_out_propagate (io_out_propagate),
        .io_err_misalign  (io_err_misalign)
`ifdef MESH_OUT_SAT_COUNT_EN
        ,
        .io_sat_count     (io_sat_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    logic [31:0] rowC [8][4];
    int          rowShift [8];
    logic        rowProp [8];
    int          rowStart [8];
    int          rowLate [8];

    logic [31:0] capC [32];
    logic        capProp [32];
    int          capCycle [32];
    int          capN;

    function automatic logic [31:0] pack4(input int e0, input int e1, input int e2, input int e3);
        return {8'(e3), 8'(e2), 8'(e1), 8'(e0)};
    endfunction

    task automatic applyStimulus(input logic [3:0] v, input logic [127:0] c,
                                 input logic [5:0] s, input logic p);
        io_in_valid     = v;
        io_in_c         = c;
        io_in_shift     = s;
        io_in_propagate = p;
    endtask

    task automatic setIdle();
        applyStimulus(4'b0000, {4{32'hDEADBEEF}}, 6'h3F, 1'b1);
    endtask

    task automatic clearRows();
        for (int r = 0; r < 8; r++) begin
            rowStart[r] = r;
            rowLate[r]  = -1;
            rowShift[r] = 0;
            rowProp[r]  = 1'b0;
            for (int j = 0; j < 4; j++) rowC[r][j] = '0;
        end
    endtask

    // Presents lane j of row r at cycle rowStart+j (plus one if that lane is the late one).
    task automatic driveRows(input int n, input int cycles);
        logic [3:0]   v;
        logic [127:0] c;
        logic [5:0]   s;
        logic         p;
        capN = 0;
        for (int cyc = 0; cyc < cycles; cyc++) begin
            v = '0;
            c = {4{32'hDEADBEEF}};
            s = 6'h3F;
            p = 1'b1;
            for (int r = 0; r < n; r++) begin
                for (int j = 0; j < 4; j++) begin
                    if (rowStart[r] + j + ((rowLate[r] == j) ? 1 : 0) == cyc) begin
                        v[j] = 1'b1;
                        c[j*32 +: 32] = rowC[r][j];
                        if (j == 0) begin
                            s = 6'(rowShift[r]);
                            p = rowProp[r];
                        end
                    end
                end
            end
            applyStimulus(v, c, s, p);
            @(posedge clock);
            #1;
            if (io_out_valid === 1'b1 && capN < 32) begin
                capC[capN]     = io_out_c;
                capProp[capN]  = io_out_propagate;
                capCycle[capN] = cyc;
                capN++;
            end
        end
        setIdle();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        setIdle();
        repeat (2) @(posedge clock);
        #1;
        total++; if (io_out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", io_out_valid); end
        total++; if (io_out_c !== 32'h0) begin bad++; $display("[TB] FAIL reset_c got=%h want=00000000", io_out_c); end
        total++; if (io_out_propagate !== 1'b0) begin bad++; $display("[TB] FAIL reset_prop got=%b want=0", io_out_propagate); end
        total++; if (io_err_misalign !== 1'b0) begin bad++; $display("[TB] FAIL reset_err got=%b want=0", io_err_misalign); end
`ifdef MESH_OUT_SAT_COUNT_EN
        total++; if (io_sat_count !== 16'd0) begin bad++; $display("[TB] FAIL reset_sat got=%0d want=0", io_sat_count); end
`endif
        reset = 1'b0;
    endtask

    task automatic test_aligned();
        logic [31:0] exp;
        clearRows();
        rowC[0][0] = 32'd100; rowC[0][1] = 32'd200; rowC[0][2] = -32'sd300; rowC[0][3] = 32'd1000;
        rowShift[0] = 2; rowProp[0] = 1'b1;
        exp = pack4(25, 50, -75, 127);
        driveRows(1, 8);
        total++; if (capN !== 1) begin bad++; $display("[TB] FAIL aligned_count got=%0d want=1", capN); end
        total++; if (capCycle[0] !== 3) begin bad++; $display("[TB] FAIL aligned_latency got=%0d want=3", capCycle[0]); end
        total++; if (capC[0] !== exp) begin bad++; $display("[TB] FAIL aligned_c got=%h want=%h", capC[0], exp); end
        total++; if (capProp[0] !== 1'b1) begin bad++; $display("[TB] FAIL aligned_prop got=%b want=1", capProp[0]); end
        total++; if (io_out_valid !== 1'b0) begin bad++; $display("[TB] FAIL idle_valid got=%b want=0", io_out_valid); end
        total++; if (io_out_c !== exp) begin bad++; $display("[TB] FAIL idle_hold got=%h want=%h", io_out_c, exp); end
        total++; if (io_err_misalign !== 1'b0) begin bad++; $display("[TB] FAIL aligned_err got=%b want=0", io_err_misalign); end
`ifdef MESH_OUT_SAT_COUNT_EN
        total++; if (io_sat_count !== 16'd1) begin bad++; $display("[TB] FAIL aligned_sat got=%0d want=1", io_sat_count); end
`endif
    endtask

    task automatic test_rounding();
        logic [31:0] exp0, exp1;
        clearRows();
        rowC[0][0] = 32'd6; rowC[0][1] = -32'sd6; rowC[0][2] = 32'd2; rowC[0][3] = -32'sd2;
        rowC[1][0] = 32'd6; rowC[1][1] = -32'sd6; rowC[1][2] = 32'd2; rowC[1][3] = -32'sd2;
        rowShift[0] = 2; rowShift[1] = 0;
        rowProp[0] = 1'b0; rowProp[1] = 1'b1;
        exp0 = pack4(2, -1, 1, 0);
        exp1 = pack4(6, -6, 2, -2);
        driveRows(2, 8);
        total++; if (capN !== 2) begin bad++; $display("[TB] FAIL round_count got=%0d want=2", capN); end
        total++; if (capC[0] !== exp0) begin bad++; $display("[TB] FAIL round_shift2 got=%h want=%h", capC[0], exp0); end
        total++; if (capC[1] !== exp1) begin bad++; $display("[TB] FAIL round_shift0 got=%h want=%h", capC[1], exp1); end
        total++; if (capProp[0] !== 1'b0 || capProp[1] !== 1'b1) begin bad++; $display("[TB] FAIL round_prop got=%b%b want=01", capProp[0], capProp[1]); end
    endtask

    task automatic test_clamp_sat();
        logic [31:0] exp0, exp1;
        clearRows();
        rowC[0][0] = 32'h8000_0000; rowC[0][1] = 32'h7FFF_FFFF; rowC[0][2] = -32'sd1000; rowC[0][3] = 32'h4000_0000;
        rowC[1][0] = -32'sd1000; rowC[1][1] = 32'h7FFF_FFFF; rowC[1][2] = 32'd5; rowC[1][3] = -32'sd128;
        rowShift[0] = 40; rowShift[1] = 0;
        exp0 = pack4(-1, 1, 0, 1);
        exp1 = pack4(-128, 127, 5, -128);
        driveRows(2, 8);
        total++; if (capN !== 2) begin bad++; $display("[TB] FAIL clamp_count got=%0d want=2", capN); end
        total++; if (capC[0] !== exp0) begin bad++; $display("[TB] FAIL clamp_shift40 got=%h want=%h", capC[0], exp0); end
        total++; if (capC[1] !== exp1) begin bad++; $display("[TB] FAIL sat_shift0 got=%h want=%h", capC[1], exp1); end
`ifdef MESH_OUT_SAT_COUNT_EN
        total++; if (io_sat_count !== 16'd3) begin bad++; $display("[TB] FAIL sat_count got=%0d want=3", io_sat_count); end
`endif
    endtask

    task automatic test_misalign();
        logic [31:0] exp;
        total++; if (io_err_misalign !== 1'b0) begin bad++; $display("[TB] FAIL err_before got=%b want=0", io_err_misalign); end
        clearRows();
        for (int j = 0; j < 4; j++) rowC[0][j] = 32'd5000;
        rowLate[0] = 2; rowShift[0] = 0;
        rowC[1][0] = -32'sd200; rowC[1][1] = 32'd40; rowC[1][2] = 32'd1; rowC[1][3] = 32'd3;
        rowStart[1] = 2; rowShift[1] = 3; rowProp[1] = 1'b1;
        exp = pack4(-25, 5, 0, 0);
        driveRows(2, 10);
        total++; if (capN !== 1) begin bad++; $display("[TB] FAIL misalign_count got=%0d want=1", capN); end
        total++; if (capCycle[0] !== 5) begin bad++; $display("[TB] FAIL misalign_next_cycle got=%0d want=5", capCycle[0]); end
        total++; if (capC[0] !== exp) begin bad++; $display("[TB] FAIL misalign_next_c got=%h want=%h", capC[0], exp); end
        total++; if (io_err_misalign !== 1'b1) begin bad++; $display("[TB] FAIL misalign_err got=%b want=1", io_err_misalign); end
`ifdef MESH_OUT_SAT_COUNT_EN
        total++; if (io_sat_count !== 16'd3) begin bad++; $display("[TB] FAIL misalign_sat got=%0d want=3", io_sat_count); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [7:0]  propPat;
        logic [31:0] exp;
        propPat = 8'b1011_0010;
        clearRows();
        for (int r = 0; r < 8; r++) begin
            for (int j = 0; j < 4; j++) rowC[r][j] = 32'(16*r + 4*j - 10);
            rowShift[r] = 2;
            rowProp[r]  = propPat[r];
        end
        driveRows(8, 14);
        total++; if (capN !== 8) begin bad++; $display("[TB] FAIL stream_count got=%0d want=8", capN); end
        for (int k = 0; k < 8; k++) begin
            exp = pack4(4*k - 2, 4*k - 1, 4*k, 4*k + 1);
            total++; if (capCycle[k] !== k + 3) begin bad++; $display("[TB] FAIL stream_cycle[%0d] got=%0d want=%0d", k, capCycle[k], k + 3); end
            total++; if (capC[k] !== exp) begin bad++; $display("[TB] FAIL stream_c[%0d] got=%h want=%h", k, capC[k], exp); end
            total++; if (capProp[k] !== propPat[k]) begin bad++; $display("[TB] FAIL stream_prop[%0d] got=%b want=%b", k, capProp[k], propPat[k]); end
        end
        total++; if (io_err_misalign !== 1'b1) begin bad++; $display("[TB] FAIL err_sticky got=%b want=1", io_err_misalign); end
    endtask

    task automatic test_reset_midflight();
        int          strayValid;
        logic [31:0] exp;
        applyStimulus(4'b0001, {96'h0, 32'd1000}, 6'd0, 1'b1);
        @(posedge clock); #1;
        applyStimulus(4'b0010, {64'h0, 32'd1000, 32'h0}, 6'd0, 1'b1);
        @(posedge clock); #1;
        setIdle();
        reset = 1'b1;
        #1;
        total++; if (io_out_c !== 32'h0) begin bad++; $display("[TB] FAIL midreset_c got=%h want=00000000", io_out_c); end
        total++; if (io_out_propagate !== 1'b0) begin bad++; $display("[TB] FAIL midreset_prop got=%b want=0", io_out_propagate); end
        total++; if (io_err_misalign !== 1'b0) begin bad++; $display("[TB] FAIL midreset_err got=%b want=0", io_err_misalign); end
`ifdef MESH_OUT_SAT_COUNT_EN
        total++; if (io_sat_count !== 16'd0) begin bad++; $display("[TB] FAIL midreset_sat got=%0d want=0", io_sat_count); end
`endif
        @(posedge clock); #1;
        reset = 1'b0;
        strayValid = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            if (io_out_valid === 1'b1) strayValid++;
        end
        total++; if (strayValid !== 0) begin bad++; $display("[TB] FAIL midreset_stray got=%0d want=0", strayValid); end
        clearRows();
        rowC[0][0] = 32'd1000; rowC[0][1] = -32'sd1000; rowC[0][2] = 32'd5; rowC[0][3] = 32'd5;
        rowShift[0] = 0;
        exp = pack4(127, -128, 5, 5);
        driveRows(1, 6);
        total++; if (capN !== 1 || capC[0] !== exp) begin bad++; $display("[TB] FAIL post_reset_row n=%0d got=%h want=%h", capN, capC[0], exp); end
`ifdef MESH_OUT_SAT_COUNT_EN
        total++; if (io_sat_count !== 16'd2) begin bad++; $display("[TB] FAIL post_reset_sat got=%0d want=2", io_sat_count); end
`endif
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_rounding();
        test_clamp_sat();
        test_misalign();
        test_back_to_back();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
